// File: rtl/spi_master_mc_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_mc_if
// Purpose  : Register-bus interface between a port-decoder front-end and the
//            spi_master_mc engine.
// Signals  : sel   - register select (0 DATA, 1 CS, 2 CTRL, 3 STATUS)
//            we    - single-cycle write strobe
//            re    - single-cycle read strobe
//            din   - write data
//            dout  - registered read data
//            ready - engine idle, TX FIFO empty, no chip-select update pending
// Modports : master - front-end side (drives strobes/data)
//            slave  - engine side (returns dout/ready)
// Revision : 1.0 - initial release
// ============================================================================
interface spi_master_mc_if #(
  parameter int DATA_W = 8
) ();
  logic [1:0]        sel;
  logic              we;
  logic              re;
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              ready;

  modport master (output sel, output we, output re, output din,
                  input  dout, input ready);
  modport slave  (input  sel, input  we, input  re, input  din,
                  output dout, output ready);
endinterface
`default_nettype wire

// File: rtl/spi_master_mc.sv
`default_nettype none
// ============================================================================
// Module   : spi_master_mc
// Purpose  : Parametrised SPI master with TX FIFO, NUM_CS chip selects, all
//            four CPOL/CPHA modes, a prescaler on the spi_ce tick and optional
//            read-ahead (a DATA read queues an all-ones dummy frame).
// Ports    : clk_sys  - system clock, rising edge
//            nRESET   - synchronous active-low reset
//            bus      - register bus (spi_master_mc_if.slave)
//            spi_ce   - base tick enable for the SPI clock prescaler
//            spi_clk  - SPI clock
//            spi_do   - MOSI
//            spi_di   - MISO
//            spi_cs_n - active-low chip selects
// Revision : 1.0 - initial release
// ============================================================================
module spi_master_mc #(
  parameter int DATA_W     = 8,
  parameter int NUM_CS     = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int READ_AHEAD = 1
) (
  input  logic              clk_sys,
  input  logic              nRESET,
  spi_master_mc_if.slave    bus,
  input  logic              spi_ce,
  output logic              spi_clk,
  output logic              spi_do,
  input  logic              spi_di,
  output logic [NUM_CS-1:0] spi_cs_n
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int TW = $clog2(2 * DATA_W) + 1;
  localparam logic [TW-1:0] LAST_TICK = TW'(2 * DATA_W - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t             state;

  // TX FIFO
  logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      fifo_cnt;

  // Engine datapath
  logic [DATA_W-1:0]  shreg;
  logic [DATA_W-1:0]  rx_sr;
  logic [DATA_W-1:0]  rx_data;
  logic [TW-1:0]      bit_cnt;
  logic [3:0]         presc;

  // Control / status
  logic               cpol;
  logic               cpha;
  logic [3:0]         div;
  logic               cs_pend;
  logic [NUM_CS-1:0]  cs_pend_val;
  logic               overrun;
  logic               ctrl_err;

  // Register decode
  logic wr_data, wr_cs, wr_ctrl;
  logic rd_data, rd_cs, rd_ctrl, rd_stat;
  assign wr_data = bus.we && (bus.sel == 2'd0);
  assign wr_cs   = bus.we && (bus.sel == 2'd1);
  assign wr_ctrl = bus.we && (bus.sel == 2'd2);
  assign rd_data = bus.re && (bus.sel == 2'd0);
  assign rd_cs   = bus.re && (bus.sel == 2'd1);
  assign rd_ctrl = bus.re && (bus.sel == 2'd2);
  assign rd_stat = bus.re && (bus.sel == 2'd3);

  logic fifo_empty, fifo_full, is_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign is_ready   = (state == ST_IDLE) && fifo_empty && !cs_pend;
  assign bus.ready  = is_ready;

  // The engine pops whenever it is between frames (IDLE or DONE).
  logic pop, push_req, push, ovr_set, ctrl_err_set;
  logic [DATA_W-1:0] push_val;
  assign pop      = ((state == ST_IDLE) || (state == ST_DONE)) && !fifo_empty;
  assign push_req = wr_data || (rd_data && (READ_AHEAD != 0));
  assign push_val = wr_data ? bus.din : {DATA_W{1'b1}};
  // A full FIFO still takes a push in the cycle it pops.
  assign push     = push_req && (!fifo_full || pop);
  assign ovr_set  = push_req && !push;
  assign ctrl_err_set = wr_ctrl && !is_ready;

  // Prescaler tick and per-edge actions. Tick n (1-based) is a leading edge
  // when n is odd, i.e. when bit_cnt (ticks already done) is even.
  logic tick, leading, do_sample, do_shift, last_tick;
  assign tick      = (state == ST_SHIFT) && spi_ce && (presc == div);
  assign leading   = ~bit_cnt[0];
  assign last_tick = (bit_cnt == LAST_TICK);
  assign do_sample = tick && (cpha ? ~leading : leading);
  // No shift on the final edge so spi_do keeps the last bit until next LOAD.
  assign do_shift  = tick && !last_tick &&
                     (cpha ? (leading && (|bit_cnt)) : ~leading);

  always_ff @(posedge clk_sys) begin
    if (push) fifo_mem[wr_ptr] <= push_val;
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!nRESET) begin
      state       <= ST_IDLE;
      spi_clk     <= 1'b0;
      spi_do      <= 1'b1;
      spi_cs_n    <= {NUM_CS{1'b1}};
      shreg       <= '0;
      rx_sr       <= {DATA_W{1'b1}};
      rx_data     <= {DATA_W{1'b1}};
      bit_cnt     <= '0;
      presc       <= '0;
      cpol        <= 1'b0;
      cpha        <= 1'b0;
      div         <= '0;
      cs_pend     <= 1'b0;
      cs_pend_val <= '0;
      overrun     <= 1'b0;
      ctrl_err    <= 1'b0;
      bus.dout    <= '0;
    end else begin
      // Register reads
      if (rd_data)      bus.dout <= rx_data;
      else if (rd_cs)   bus.dout <= DATA_W'(~spi_cs_n);
      else if (rd_ctrl) bus.dout <= DATA_W'({div, 2'b00, cpol, cpha});
      else if (rd_stat) bus.dout <= DATA_W'({ctrl_err, overrun, ~is_ready});

      // Sticky flags: a STATUS read clears them, but a flag raised in the
      // same cycle wins over the clear.
      overrun  <= (rd_stat ? 1'b0 : overrun)  | ovr_set;
      ctrl_err <= (rd_stat ? 1'b0 : ctrl_err) | ctrl_err_set;

      if (wr_ctrl && is_ready) begin
        div  <= bus.din[7:4];
        cpol <= bus.din[1];
        cpha <= bus.din[0];
      end

      // Chip select: immediate when nothing is queued, otherwise deferred to
      // the DONE that drains the FIFO. A write landing in that DONE cycle is
      // the newest value and is applied directly.
      if ((state == ST_DONE) && fifo_empty) begin
        if (wr_cs)        spi_cs_n <= ~bus.din[NUM_CS-1:0];
        else if (cs_pend) spi_cs_n <= ~cs_pend_val;
        cs_pend <= 1'b0;
      end else if (wr_cs) begin
        if ((state == ST_IDLE) && fifo_empty) begin
          spi_cs_n <= ~bus.din[NUM_CS-1:0];
        end else begin
          cs_pend     <= 1'b1;
          cs_pend_val <= bus.din[NUM_CS-1:0];
        end
      end

      case (state)
        ST_IDLE: begin
          spi_clk <= cpol;
          if (!fifo_empty) begin
            shreg   <= fifo_mem[rd_ptr];
            bit_cnt <= '0;
            state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          spi_do <= shreg[DATA_W-1];
          presc  <= '0;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (spi_ce) begin
            if (presc == div) begin
              presc   <= '0;
              spi_clk <= ~spi_clk;
              bit_cnt <= bit_cnt + TW'(1);
              if (do_sample) rx_sr <= {rx_sr[DATA_W-2:0], spi_di};
              if (do_shift) begin
                shreg  <= {shreg[DATA_W-2:0], 1'b0};
                spi_do <= shreg[DATA_W-2];
              end
              if (last_tick) state <= ST_DONE;
            end else begin
              presc <= presc + 4'd1;
            end
          end
        end
        ST_DONE: begin
          rx_data <= rx_sr;
          if (!fifo_empty) begin
            shreg   <= fifo_mem[rd_ptr];
            bit_cnt <= '0;
            state   <= ST_LOAD;
          end else begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/spi_master_mc.md
Name: spi_master_mc

Overview:
- Parametrised SPI master; successor to the single-channel divmmc SPI engine.
- Adds configurable frame width, NUM_CS chip selects, all four CPOL/CPHA modes, a programmable prescaler on the spi_ce tick and a TX FIFO.
- Sits between a port decoder (divmmc, zxmmc and future SD/flash front-ends) and the SPI pins.
- Keeps divmmc read-ahead semantics as an option.

Parameters:
- DATA_W, 8: frame width in bits, legal 8..16; bus width of din/dout.
- NUM_CS, 2: chip-select lines, 1..8.
- FIFO_DEPTH, 4: TX FIFO entries; power of 2, ≥2.
- READ_AHEAD, 1: a DATA read queues an all-ones dummy frame.

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- nRESET  in  1  synchronous active-low reset.
- sel  in  2  register select: 0 DATA, 1 CS, 2 CTRL, 3 STATUS.
- we  in  1  single-cycle write strobe; the front-end does edge detection.
- re  in  1  single-cycle read strobe.
- din  in  DATA_W  write data.
- dout  out  DATA_W  read data, registered.
- ready  out  1  high when engine idle, FIFO empty and no CS pending.
- spi_ce  in  1  base tick enable.
- spi_clk  out  1  SPI clock.
- spi_do  out  1  MOSI.
- spi_di  in  1  MISO.
- spi_cs_n  out  NUM_CS  active-low chip selects.

Behaviour:
- Reset (nRESET=0 at clk edge), takes effect even mid-transfer:
  - FIFO empty, engine IDLE, transfer aborted.
  - spi_cs_n all 1s; CS pending cleared.
  - CTRL=0 (mode 0, div 0); spi_clk=0, spi_do=1.
  - rx_data all 1s, dout 0, STATUS flags 0, ready=1.
- Registers:
  - CTRL [1] CPOL, [0] CPHA, [7:4] div: half-period = (div+1) spi_ce ticks.
  - STATUS [0] busy = ~ready, [1] overrun, [2] ctrl_err; [1] and [2] are sticky.
- DATA write: push din into the FIFO. If the FIFO is full, drop din and set overrun.
- DATA read:
  - dout <= rx_data on the next edge (1-cycle latency).
  - If READ_AHEAD, push all-ones; if the FIFO is full, set overrun and push nothing.
- CS write:
  - Idle and FIFO empty: spi_cs_n <= ~din[NUM_CS-1:0] on the next edge.
  - Otherwise: held pending and applied the cycle after the last queued frame completes. A later CS write overwrites the pending value.
- CTRL write:
  - Applied only when ready=1.
  - Otherwise ignored and ctrl_err set.
- STATUS read: returns flags, then clears [2:1] in the same edge. A flag set in that same cycle survives the clear.
- Simultaneous push and pop: both occur; occupancy is unchanged. A full FIFO accepts a push in the cycle it pops.
- FSM states:
  - IDLE: spi_clk=CPOL. If FIFO non-empty, pop into shreg, clear the bit counter, go to LOAD.
  - LOAD: one cycle. spi_do=shreg[MSB]; prescaler cleared. Go to SHIFT.
  - SHIFT: prescaler counts spi_ce pulses; at count==div it issues a tick and resets.
    - Each tick toggles spi_clk.
    - CPHA=0: sample spi_di on leading (odd) edges into the LSB; shift shreg left on trailing edges.
    - CPHA=1: shift on leading edges except the first; sample on trailing edges.
    - After 2*DATA_W ticks go to DONE; spi_clk is back at CPOL.
  - DONE: one cycle. rx_data <= received frame. If FIFO non-empty go to LOAD, else IDLE (apply pending CS here).
- MSB first. spi_do is held stable between shifts.
- spi_ce low: the transfer freezes with no glitches.
- Prescaler, div=15: half-period = 16 ticks.
- Frame length in spi_ce ticks (spi_ce always high): 2*DATA_W*(div+1). Plus 2 fixed cycles (LOAD, DONE) per frame.

Test Plan:
- Reset, then CS write 0x01, then DATA write 0xA5 with spi_di looping spi_do, mode 0, div 0, spi_ce=1.
  - spi_cs_n=2'b10; 16 spi_clk edges; spi_do bits 1,0,1,0,0,1,0,1.
  - ready returns after 2+16 cycles; DATA read gives 0xA5 and queues 0xFF.
- Modes 1, 2, 3 with a slave model returning 0x3C.
  - rx_data=0x3C in every mode; idle spi_clk equals CPOL; sample edge follows CPHA.
- Write 5 frames back-to-back with FIFO_DEPTH=4, engine busy.
  - First 4 transmitted contiguously (DONE to LOAD, no IDLE); 5th dropped.
  - STATUS=0x03, then 0x01/0x00 after the read clears it.
- CS write 0x02 while 2 frames are queued.
  - spi_cs_n unchanged until the DONE of frame 2, then 2'b01.
  - CTRL write while busy is ignored and STATUS[2]=1.
- div=3, spi_ce pulsing every 3rd cycle: each spi_clk half-period = 12 clk_sys cycles.
- nRESET low mid-frame (bit 4):
  - Next edge: spi_cs_n all 1s, spi_clk 0, spi_do 1, FIFO empty, ready=1.
  - No further spi_clk edges.
